// File: rtl/gas_code_pkg.sv
// Shared constants for the gas alarm-code transmitter: the three codes,
// their lengths, class indices and the transmitter state encoding.
package gas_code_pkg;

  localparam logic [1:0] CLS_C0 = 2'd0;
  localparam logic [1:0] CLS_C1 = 2'd1;
  localparam logic [1:0] CLS_C2 = 2'd2;

  // Codes are left-aligned so the MSB always sits at bit 11 of the shifter.
  localparam logic [11:0] C0 = {10'b1011101010, 2'b00};
  localparam logic [11:0] C1 = 12'b101010010011;
  localparam logic [11:0] C2 = {9'b100100100, 3'b000};

  localparam logic [3:0] LEN0 = 4'd10;
  localparam logic [3:0] LEN1 = 4'd12;
  localparam logic [3:0] LEN2 = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_e;

  function automatic logic [11:0] codeOf(input logic [1:0] cls);
    case (cls)
      CLS_C0:  codeOf = C0;
      CLS_C1:  codeOf = C1;
      default: codeOf = C2;
    endcase
  endfunction

  function automatic logic [3:0] lenOf(input logic [1:0] cls);
    case (cls)
      CLS_C0:  lenOf = LEN0;
      CLS_C1:  lenOf = LEN1;
      default: lenOf = LEN2;
    endcase
  endfunction

endpackage

// File: rtl/gas_req_arbiter.sv
// Pending-request register with fixed priority C0 > C1 > C2. A request that
// arrives on the same edge its class is taken stays pending.
module gas_req_arbiter
  import gas_code_pkg::*;
(
  input  logic       clk_i,
  input  logic       arst_ni,
  input  logic [2:0] req_i,
  input  logic       take_i,
  output logic [1:0] grantCls_o,
  output logic       grantValid_o,
  output logic [2:0] pending_o
);

  logic [2:0] pending_q;
  logic [2:0] pending_d;
  logic [2:0] clear;

  always_comb begin
    grantValid_o = |pending_q;
    grantCls_o   = CLS_C0;
    if (pending_q[0])      grantCls_o = CLS_C0;
    else if (pending_q[1]) grantCls_o = CLS_C1;
    else if (pending_q[2]) grantCls_o = CLS_C2;
    clear = 3'b000;
    if (take_i && grantValid_o) clear[grantCls_o] = 1'b1;
    pending_d = (pending_q & ~clear) | req_i;
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) pending_q <= 3'b000;
    else          pending_q <= pending_d;
  end

  assign pending_o = pending_q;

endmodule

// File: rtl/gas_code_transmitter.sv
// Serial alarm-code transmitter: one code bit per clock, MSB first, each
// frame followed by GAP_BITS zeros and one idle cycle before the next load.
module gas_code_transmitter
  import gas_code_pkg::*;
#(
  parameter int GAP_BITS = 4
) (
  input  logic       clk_i,
  input  logic       arst_ni,
  input  logic [2:0] req_i,
  output logic       dout_o,
  output logic       busy_o,
  output logic [2:0] sent_o,
  output logic [2:0] pending_o
);

  state_e      state_q;
  logic [11:0] shift_q;
  logic [3:0]  bitCnt_q;
  logic [3:0]  gapCnt_q;
  logic [1:0]  curCls_q;
  logic        dout_q;

  logic        take;
  logic [1:0]  grantCls;
  logic        grantValid;
  logic [11:0] grantCode;

  assign take      = (state_q == IDLE);
  assign grantCode = codeOf(grantCls);

  gas_req_arbiter u_arbiter (
    .clk_i        (clk_i),
    .arst_ni      (arst_ni),
    .req_i        (req_i),
    .take_i       (take),
    .grantCls_o   (grantCls),
    .grantValid_o (grantValid),
    .pending_o    (pending_o)
  );

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      bitCnt_q <= '0;
      gapCnt_q <= '0;
      curCls_q <= CLS_C0;
      dout_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          dout_q <= 1'b0;
          if (grantValid) begin
            shift_q  <= grantCode;
            bitCnt_q <= lenOf(grantCls) - 4'd1;
            curCls_q <= grantCls;
            dout_q   <= grantCode[11];
            state_q  <= SEND;
          end
        end
        SEND: begin
          shift_q <= shift_q << 1;
          if (bitCnt_q == 4'd0) begin
            dout_q   <= 1'b0;
            gapCnt_q <= 4'(GAP_BITS - 1);
            state_q  <= GAP;
          end else begin
            dout_q   <= shift_q[10];
            bitCnt_q <= bitCnt_q - 4'd1;
          end
        end
        GAP: begin
          dout_q <= 1'b0;
          if (gapCnt_q == 4'd0) state_q  <= IDLE;
          else                  gapCnt_q <= gapCnt_q - 4'd1;
        end
        default: begin
          state_q <= IDLE;
          dout_q  <= 1'b0;
        end
      endcase
    end
  end

  assign dout_o = dout_q;
  assign busy_o = (state_q != IDLE);
  assign sent_o = (state_q == SEND && bitCnt_q == 4'd0) ? 3'(3'b001 << curCls_q) : 3'b000;

endmodule

// File: tb/tb_gas_code_transmitter.sv
// Randomised bench for gas_code_transmitter against a frame-schedule model
// that expands each granted request into its line bits, gap and idle cycle.
module tb_gas_code_transmitter;

  localparam int GAP_BITS = 4;

  logic       clk_i;
  logic       arst_ni;
  logic [2:0] req_i;
  logic       dout_o;
  logic       busy_o;
  logic [2:0] sent_o;
  logic [2:0] pending_o;

  gas_code_transmitter #(.GAP_BITS(GAP_BITS)) dut (
    .clk_i     (clk_i),
    .arst_ni   (arst_ni),
    .req_i     (req_i),
    .dout_o    (dout_o),
    .busy_o    (busy_o),
    .sent_o    (sent_o),
    .pending_o (pending_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       dout;
    logic       busy;
    logic [2:0] sent;
  } lineCycle_t;

  // Codes right-aligned with explicit lengths; bit i of a frame is code[len-1-i].
  logic [11:0] codeVal [3];
  int          codeLen [3];

  lineCycle_t  mSched [$];
  lineCycle_t  mCur;
  logic [2:0]  mPend;

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    mSched.delete();
    mCur  = '{dout: 1'b0, busy: 1'b0, sent: 3'b000};
    mPend = 3'b000;
  endtask

  task automatic buildFrame(input int k);
    lineCycle_t c;
    for (int i = 0; i < codeLen[k]; i++) begin
      c.dout = codeVal[k][codeLen[k] - 1 - i];
      c.busy = 1'b1;
      c.sent = (i == codeLen[k] - 1) ? 3'(1 << k) : 3'b000;
      mSched.push_back(c);
    end
    for (int i = 0; i < GAP_BITS; i++) begin
      c = '{dout: 1'b0, busy: 1'b1, sent: 3'b000};
      mSched.push_back(c);
    end
  endtask

  task automatic modelEdge(input logic [2:0] r);
    logic [2:0] clr;
    int k;
    clr = 3'b000;
    if (mSched.size() > 0) begin
      mCur = mSched.pop_front();
    end else if (!mCur.busy && mPend != 3'b000) begin
      k = mPend[0] ? 0 : (mPend[1] ? 1 : 2);
      clr[k] = 1'b1;
      buildFrame(k);
      mCur = mSched.pop_front();
    end else begin
      mCur = '{dout: 1'b0, busy: 1'b0, sent: 3'b000};
    end
    mPend = (mPend & ~clr) | r;
  endtask

  task automatic compareAll(input string tag);
    checkOutput({tag, ".dout"},    32'(dout_o),    32'(mCur.dout));
    checkOutput({tag, ".busy"},    32'(busy_o),    32'(mCur.busy));
    checkOutput({tag, ".sent"},    32'(sent_o),    32'(mCur.sent));
    checkOutput({tag, ".pending"}, 32'(pending_o), 32'(mPend));
  endtask

  task automatic applyStimulus(input logic [2:0] r, input string tag);
    @(negedge clk_i);
    req_i = r;
    @(posedge clk_i);
    modelEdge(r);
    #1;
    req_i = 3'b000;
    compareAll(tag);
  endtask

  // Asynchronous reset asserted between edges, held for a few edges.
  task automatic midCycleReset(input int holdCycles);
    #2;
    arst_ni = 1'b0;
    #1;
    modelReset();
    compareAll("asyncRst");
    for (int i = 0; i < holdCycles; i++) begin
      @(negedge clk_i);
      req_i = 3'($urandom_range(0, 7));
      @(posedge clk_i);
      #1;
      req_i = 3'b000;
      compareAll("inRst");
    end
    @(negedge clk_i);
    arst_ni = 1'b1;
  endtask

  logic [9:0] c0Got;
  logic [2:0] r;

  initial begin
    codeVal[0] = 12'b001011101010; codeLen[0] = 10;
    codeVal[1] = 12'b101010010011; codeLen[1] = 12;
    codeVal[2] = 12'b000100100100; codeLen[2] = 9;
    req_i   = 3'b000;
    arst_ni = 1'b0;
    modelReset();

    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i);
      #1;
      compareAll("reset");
    end
    @(negedge clk_i);
    arst_ni = 1'b1;

    for (int i = 0; i < 20; i++) applyStimulus(3'b000, "idle");

    applyStimulus(3'b001, "c0Req");
    c0Got = '0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(3'b000, "c0Frame");
      c0Got = {c0Got[8:0], dout_o};
    end
    checkOutput("c0Bits", 32'(c0Got), 32'(10'b1011101010));
    for (int i = 0; i < 8; i++) applyStimulus(3'b000, "c0Gap");

    applyStimulus(3'b111, "allReq");
    for (int i = 0; i < 50; i++) applyStimulus(3'b000, "allFrames");

    applyStimulus(3'b010, "c1Req");
    for (int i = 0; i < 6; i++) applyStimulus(3'b000, "c1Frame");
    applyStimulus(3'b010, "c1ReReq");
    checkOutput("c1RePending", 32'(pending_o[1]), 32'd1);
    for (int i = 0; i < 40; i++) applyStimulus(3'b000, "c1Again");

    applyStimulus(3'b100, "c2Req");
    for (int i = 0; i < 5; i++) applyStimulus(3'b000, "c2Frame");
    midCycleReset(2);
    for (int i = 0; i < 20; i++) applyStimulus(3'b000, "afterRst");

    for (int i = 0; i < 1500; i++) begin
      r = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      applyStimulus(r, "rand");
      if ($urandom_range(0, 299) == 0) midCycleReset(int'($urandom_range(1, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
